// File: rtl/noise_test_pkg.sv
// Shared types and default constants for the noise-tester test sequencer.
package noise_test_pkg;

  // Sequencer states: idle, loop-latency flush, counted window, result hold.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam int DEF_BITS_PER_TEST = 1000;
  localparam int DEF_SETTLE_TICKS  = 4;
  localparam int DEF_HOLD_TICKS    = 200;
  localparam int DEF_CNT_W         = 10;

  // Bits needed to hold any value in 0..max_val.
  function automatic int count_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Increments when both
// enable and inc are high and the count is below all-ones; never wraps.
// The combinational next value is exported so a caller can latch the
// count including the increment happening on the same edge.
module sat_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_next
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] r_count;

  // Next-value selection: clear wins, then a saturating increment.
  always_comb begin
    // NOTE: assign a default first so every path drives o_next and no latch is inferred.
    o_next = r_count;
    if (i_clear) begin
      o_next = '0;
    end else if (i_enable && i_inc && (r_count != MAX_VAL)) begin
      o_next = r_count + WIDTH'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= o_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/noise_test_controller.sv
// Bit-error-rate test sequencer: gates the message generator, flushes loop
// latency with settle ticks, counts XOR mismatches over a fixed window of
// sample points and latches the result for the display path, once or
// repeatedly in continuous mode.
module noise_test_controller
  import noise_test_pkg::*;
#(
  parameter int BITS_PER_TEST = DEF_BITS_PER_TEST,
  parameter int SETTLE_TICKS  = DEF_SETTLE_TICKS,
  parameter int HOLD_TICKS    = DEF_HOLD_TICKS,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic                                 continuous,
  input  logic                                 sample_tick,
  input  logic                                 err_bit,
  output logic                                 tx_enable,
  output logic                                 busy,
  output logic                                 done,
  output logic [CNT_W-1:0]                     live_count,
  output logic [CNT_W-1:0]                     result_count,
  output logic                                 saturated,
  output logic [$clog2(BITS_PER_TEST+1)-1:0]   bit_count,
  output logic [7:0]                           tests_done
);

  localparam int BC_W = $clog2(BITS_PER_TEST + 1);
  localparam int ST_W = count_width(SETTLE_TICKS);
  localparam int HD_W = count_width(HOLD_TICKS);

  localparam logic [BC_W-1:0]  BIT_LAST    = BC_W'(BITS_PER_TEST - 1);
  localparam logic [ST_W-1:0]  SETTLE_LAST = ST_W'(SETTLE_TICKS - 1);
  localparam logic [HD_W-1:0]  HOLD_LAST   = HD_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  // With no settle phase a new window goes straight to counting.
  localparam state_t FIRST_STATE = (SETTLE_TICKS == 0) ? MEASURE : SETTLE;

  state_t           r_state;
  logic             r_tx_enable;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_result;
  logic             r_saturated;
  logic [BC_W-1:0]  r_bit_count;
  logic [7:0]       r_tests_done;
  logic [ST_W-1:0]  r_settle_cnt;
  logic [HD_W-1:0]  r_hold_cnt;

  logic             w_restart;
  logic             w_live_clear;
  logic             w_live_enable;
  logic [CNT_W-1:0] w_live_count;
  logic [CNT_W-1:0] w_live_next;

  // A new window begins on start from IDLE/HOLD or when the continuous-mode
  // hold period expires; abort suppresses both.
  assign w_restart = !abort &&
                     ((start && ((r_state == IDLE) || (r_state == HOLD))) ||
                      ((r_state == HOLD) && continuous && sample_tick &&
                       (r_hold_cnt == HOLD_LAST)));

  assign w_live_clear  = abort || w_restart;
  assign w_live_enable = (r_state == MEASURE) && sample_tick;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_live_cnt (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_live_clear),
    .i_enable (w_live_enable),
    .i_inc    (err_bit),
    .o_count  (w_live_count),
    .o_next   (w_live_next)
  );

  // Sequencer FSM with tick counters, registered outputs and result latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_tx_enable  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_result     <= '0;
      r_saturated  <= 1'b0;
      r_bit_count  <= '0;
      r_tests_done <= '0;
      r_settle_cnt <= '0;
      r_hold_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state      <= IDLE;
        r_tx_enable  <= 1'b0;
        r_busy       <= 1'b0;
        r_bit_count  <= '0;
        r_settle_cnt <= '0;
        r_hold_cnt   <= '0;
      end else if (w_restart) begin
        r_state      <= FIRST_STATE;
        r_tx_enable  <= 1'b1;
        r_busy       <= 1'b1;
        r_bit_count  <= '0;
        r_settle_cnt <= '0;
        r_hold_cnt   <= '0;
      end else begin
        case (r_state)
          SETTLE: begin
            if (sample_tick) begin
              if (r_settle_cnt == SETTLE_LAST) begin
                r_state <= MEASURE;
              end else begin
                r_settle_cnt <= r_settle_cnt + ST_W'(1);
              end
            end
          end
          MEASURE: begin
            if (sample_tick) begin
              r_bit_count <= r_bit_count + BC_W'(1);
              if (r_bit_count == BIT_LAST) begin
                // Final tick: latch the count including this tick's error.
                r_state      <= HOLD;
                r_tx_enable  <= 1'b0;
                r_busy       <= 1'b0;
                r_done       <= 1'b1;
                r_result     <= w_live_next;
                r_saturated  <= (w_live_next == CNT_MAX);
                r_tests_done <= r_tests_done + 8'd1;
                r_hold_cnt   <= '0;
              end
            end
          end
          HOLD: begin
            // Counter freezes while continuous is low.
            if (continuous && sample_tick) begin
              r_hold_cnt <= r_hold_cnt + HD_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign tx_enable    = r_tx_enable;
  assign busy         = r_busy;
  assign done         = r_done;
  assign live_count   = w_live_count;
  assign result_count = r_result;
  assign saturated    = r_saturated;
  assign bit_count    = r_bit_count;
  assign tests_done   = r_tests_done;

endmodule

// File: doc/noise_test_controller.md
Name: noise_test_controller

Overview:
Test sequencer for the noise-tester loop. It gates the message generator (tx_enable) and flushes loop latency with settle samples. It then runs a fixed-length measurement window of BITS_PER_TEST sample points, accumulating XOR mismatches into a saturating error count. At window end it latches the result for the BCD/display path, either once or repeating in continuous mode. It sits between the start/run inputs and the signal generator / error-count path, replacing free-running counting with bounded, repeatable bit-error-rate tests.

Parameters:
BITS_PER_TEST, 1000, number of counted sample points per test window (>=1)
SETTLE_TICKS, 4, sample ticks with tx enabled but errors ignored before counting (0 = skip SETTLE)
HOLD_TICKS, 200, sample ticks spent in HOLD before auto-restart in continuous mode (>=1)
CNT_W, 10, width of error counts; saturate at 2^CNT_W-1

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-clk pulse (already edge-detected); begins a test
abort  input  1  level; forces IDLE
continuous  input  1  1 = auto-restart after HOLD
sample_tick  input  1  one-clk strobe at each mid-bit sample point
err_bit  input  1  XOR mismatch, valid when sample_tick=1
tx_enable  output  1  enables the message generator
busy  output  1  high in SETTLE or MEASURE
done  output  1  one-clk pulse when result_count updates
live_count  output  CNT_W  running error count of the current window
result_count  output  CNT_W  latched error count of the last completed window
saturated  output  1  latched: last completed window hit 2^CNT_W-1
bit_count  output  $clog2(BITS_PER_TEST+1)  counted sample points in the current window
tests_done  output  8  completed-window counter; wraps at 255->0

Behaviour:
- Reset: state=IDLE. All outputs 0. Internal tick counters 0.
- States: IDLE, SETTLE, MEASURE, HOLD. All outputs are registered.
- IDLE: tx_enable=0.
  - start=1 -> next cycle SETTLE (or MEASURE if SETTLE_TICKS=0).
  - On that transition, clear live_count, bit_count and the settle counter.
  - result_count is kept.
- SETTLE: tx_enable=1, busy=1.
  - Count sample_tick; err_bit is ignored.
  - On the SETTLE_TICKS-th tick -> MEASURE next cycle.
- MEASURE: tx_enable=1, busy=1.
  - Each sample_tick: bit_count+1.
  - If err_bit=1: live_count+1, saturating at 2^CNT_W-1 with no wrap.
  - On the tick that makes bit_count=BITS_PER_TEST, that tick is counted. On the next cycle:
    - state=HOLD, tx_enable=0, busy=0;
    - result_count<=final live_count, including that tick's error;
    - saturated<=(final==max);
    - done=1 for exactly one clk;
    - tests_done+1.
- HOLD: tx_enable=0. live_count and bit_count keep their final values.
  - start=1 -> restart as from IDLE.
  - continuous=1: count HOLD_TICKS sample ticks, then restart.
  - continuous=0: remain in HOLD indefinitely until start or abort.
- start during SETTLE/MEASURE is ignored; it does not restart the window.
- abort=1 in any state -> IDLE next cycle.
  - tx_enable=0, live_count=0, bit_count=0.
  - result_count, saturated and tests_done are unchanged; no done pulse.
  - abort has priority over start and over window completion in the same cycle.
- continuous deasserted mid-HOLD: hold-tick counter freezes and the block stays in HOLD.
- sample_tick coincident with a state transition is credited to the state being left. The first tick credited to the new state is the next one.
- reset mid-test: same as power-up reset. result_count is cleared.

Decomposition:
- Package noise_test_pkg: state enum (IDLE, SETTLE, MEASURE, HOLD) and default parameter constants (BITS_PER_TEST=1000, CNT_W=10).
- One natural sub-module: sat_counter.
  - Parameterised width; clear, inc and enable inputs; saturates at max.
  - Used for live_count. Optionally also for bit_count.
- FSM, tick counters and result latch live in noise_test_controller.

Test Plan:
- Reset, then start with err_bit=0, BITS_PER_TEST=1000, SETTLE_TICKS=4:
  - tx_enable rises 1 clk after start;
  - busy lasts 1004 ticks;
  - done pulses once;
  - result_count=0; tests_done=1.
- err_bit=1 on ticks 1-4 (settle) and on every 10th measured tick:
  - result_count=100;
  - settle errors not counted.
- CNT_W=4, err_bit=1 always:
  - live_count sticks at 15;
  - result_count=15; saturated=1.
- abort asserted at bit_count=500 after a prior result of 100:
  - IDLE next clk; tx_enable=0; live_count=0;
  - result_count stays 100; no done; tests_done unchanged.
- continuous=1, HOLD_TICKS=200:
  - windows repeat with tx_enable low for exactly 200 ticks between them;
  - tests_done wraps 255->0 after 256 windows.
- start pulse mid-MEASURE, plus start and abort in the same clk in HOLD:
  - mid-MEASURE start has no effect; bit_count continues;
  - simultaneous start+abort goes to IDLE (abort wins).
